core_dequant: RTL and testbench
===============================

// Module: core_dequant
// PURPOSE
//  Inverse of the core requantizer. Expands a stream of signed int8 activations
//  back to wide signed fixed point: odata = sat(((idata - zp) * scale) <<< shift).
//  Sits between an int8 activation buffer and the wide accumulator/residual path.
//  Three-stage stallable pipeline with valid/ready on both sides, plus vector-boundary tagging.
// PARAMETERS
//  IDATA_BIT          8   input element width (signed)
//  ODATA_WIDTH        25  output width (signed), saturated
//  CDATA_ZP_WIDTH     8   zero-point width (signed)
//  CDATA_SCALE_WIDTH  10  scale width (unsigned)
//  CDATA_SHIFT_WIDTH  5   left-shift amount width
//  CDATA_LEN_WIDTH    16  vector length counter width
// PORTS
//  clk               in   1                  clock
//  rstn              in   1                  async reset, active low
//  cfg_dequant_zp    in   CDATA_ZP_WIDTH     signed zero point
//  cfg_dequant_scale in   CDATA_SCALE_WIDTH  unsigned scale
//  cfg_dequant_shift in   CDATA_SHIFT_WIDTH  left shift, 0..31
//  cfg_vec_len       in   CDATA_LEN_WIDTH    elements per vector; 0 treated as 1
//  idata             in   IDATA_BIT          signed int8 element
//  idata_valid       in   1                  input beat valid
//  idata_ready       out  1                  input accepted when valid&ready
//  odata             out  ODATA_WIDTH        dequantized element
//  odata_valid       out  1                  output beat valid
//  odata_ready       in   1                  downstream accept
//  odata_last        out  1                  marks final element of a vector
//  busy              out  1                  any pipeline stage holds valid data
// BEHAVIOUR
//  - Reset: idata_ready=1 after reset; odata=0, odata_valid=0, odata_last=0, busy=0,
//    all stage valids and element counter cleared. Reset mid-stream discards in-flight data.
//  - Global enable: adv = ~odata_valid | odata_ready; idata_ready = adv. All stages
//    shift only when adv=1; on adv=0 every stage, incl. odata, holds (no drop/duplicate).
//  - S1: diff = $signed(idata) - $signed(cfg_dequant_zp), 9b signed, exact.
//  - S2: prod = diff * $signed({1'b0,scale}), 20b signed, exact.
//  - S3: wide = prod <<< shift in 51b signed; saturate to ODATA_WIDTH:
//    > 2^(W-1)-1 -> 2^(W-1)-1; < -2^(W-1) -> -2^(W-1); else truncate.
//  - Latency: 3 cycles from accepted input to odata_valid when odata_ready held 1.
//    Throughput 1 elem/cycle. Bubbles are not compacted.
//  - Stage valid bits propagate with data; stage data registers load only when adv
//    and the upstream valid is 1.
//  - Element counter: increments on each output handshake (odata_valid&odata_ready).
//    odata_last=1 on the beat where count==max(cfg_vec_len,1)-1; that handshake wraps count
//    to 0. odata_last is computed for S3 data and held with odata while stalled.
//  - busy = OR of all stage valids.
//  - cfg_* must be stable while busy=1; changes while busy give undefined data, never a
//    hang or lost beat.
// CONFIGURATION
//  DEQUANT_SAT_CNT_EN defined: adds ports
//    cfg_sat_cnt_clr in 1 (sync clear) and sat_cnt out 16 (reset 0).
//    sat_cnt increments on each output handshake whose value was clipped by S3 saturation.
//    It sticks at 16'hFFFF. Clear has priority over increment in the same cycle.
//  Not defined: ports and counter absent; datapath and timing identical.
// TESTING
//  1 zp=2,scale=3,shift=1, idata=5 -> odata=18, odata_valid exactly 3 cycles after accept.
//  2 zp=-128,scale=1023,shift=31, idata=127 -> odata=25'h0FFFFFF.
//    zp=127,shift=20, idata=-128 -> 25'h1000000. sat_cnt=2 under macro.
//  3 Stream 0..9, odata_ready=0 for cycles 4..8 -> idata_ready=0 during stall.
//    Outputs in order, exactly 10 beats, no duplicates.
//  4 cfg_vec_len=4, stream 8 beats -> odata_last on beats 4 and 8 only.
//    cfg_vec_len=0 -> odata_last on every beat.
//  5 Assert rstn low with 3 beats in flight -> odata_valid=0, busy=0, counter=0.
//    Next vector's odata_last timing restarts from beat 1.
//  6 zp=0,scale=1,shift=0, idata=-1 -> odata=25'h1FFFFFF (sign-extended, no saturation).

Source files
------------

// File: rtl/core_dequant.sv
// ---------------------------------------------------------------------------
// core_dequant
//   Inverse of the core requantizer. Expands a stream of signed int8
//   activations back to wide signed fixed point:
//     odata = sat(((idata - zp) * scale) <<< shift)
//   Three-stage stallable pipeline (S1 subtract, S2 multiply, S3 shift and
//   saturate) with valid/ready on both sides and vector-boundary tagging.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   cfg_dequant_zp     signed zero point
//   cfg_dequant_scale  unsigned scale
//   cfg_dequant_shift  left shift amount, 0..31
//   cfg_vec_len        elements per vector (0 behaves as 1)
//   idata/_valid/_ready  input stream (signed int8)
//   odata/_valid/_ready  output stream (signed, saturated)
//   odata_last         final element of a vector
//   busy               any pipeline stage holds valid data
//
// Optional build macro DEQUANT_SAT_CNT_EN adds:
//   cfg_sat_cnt_clr    synchronous clear of sat_cnt (wins over increment)
//   sat_cnt            saturating count of clipped output handshakes
// ---------------------------------------------------------------------------
module core_dequant #(
    parameter int IDATA_BIT         = 8,
    parameter int ODATA_WIDTH       = 25,
    parameter int CDATA_ZP_WIDTH    = 8,
    parameter int CDATA_SCALE_WIDTH = 10,
    parameter int CDATA_SHIFT_WIDTH = 5,
    parameter int CDATA_LEN_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
`ifdef DEQUANT_SAT_CNT_EN
    input  logic                         cfg_sat_cnt_clr,
    output logic [15:0]                  sat_cnt,
`endif
    input  logic [CDATA_ZP_WIDTH-1:0]    cfg_dequant_zp,
    input  logic [CDATA_SCALE_WIDTH-1:0] cfg_dequant_scale,
    input  logic [CDATA_SHIFT_WIDTH-1:0] cfg_dequant_shift,
    input  logic [CDATA_LEN_WIDTH-1:0]   cfg_vec_len,
    input  logic [IDATA_BIT-1:0]         idata,
    input  logic                         idata_valid,
    output logic                         idata_ready,
    output logic [ODATA_WIDTH-1:0]       odata,
    output logic                         odata_valid,
    input  logic                         odata_ready,
    output logic                         odata_last,
    output logic                         busy
);

    // One guard bit over the wider operand keeps the subtraction exact.
    localparam int DIFF_W = ((IDATA_BIT > CDATA_ZP_WIDTH) ? IDATA_BIT : CDATA_ZP_WIDTH) + 1;
    // Scale is zero-extended by one bit to become a non-negative signed operand.
    localparam int PROD_W = DIFF_W + CDATA_SCALE_WIDTH + 1;
    localparam int WIDE_W = PROD_W + (2 ** CDATA_SHIFT_WIDTH) - 1;

    localparam logic [ODATA_WIDTH-1:0] SAT_MAX = {1'b0, {(ODATA_WIDTH-1){1'b1}}};
    localparam logic [ODATA_WIDTH-1:0] SAT_MIN = {1'b1, {(ODATA_WIDTH-1){1'b0}}};

    // ---------------- pipeline control ----------------
    logic adv;
    logic s1_valid_q, s2_valid_q, s3_valid_q;

    // The whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign adv         = ~s3_valid_q | odata_ready;
    assign idata_ready = adv;
    assign odata_valid = s3_valid_q;
    assign busy        = s1_valid_q | s2_valid_q | s3_valid_q;

    // ---------------- S1: subtract zero point ----------------
    logic signed [DIFF_W-1:0] idata_ext, zp_ext, diff_d, s1_diff_q;

    assign idata_ext = DIFF_W'($signed(idata));
    assign zp_ext    = DIFF_W'($signed(cfg_dequant_zp));
    assign diff_d    = idata_ext - zp_ext;

    // ---------------- S2: multiply by scale ----------------
    logic signed [PROD_W-1:0] diff_ext, scale_ext, prod_d, s2_prod_q;

    assign diff_ext  = PROD_W'(s1_diff_q);
    assign scale_ext = PROD_W'({1'b0, cfg_dequant_scale});
    assign prod_d    = diff_ext * scale_ext;

    // ---------------- S3: shift and saturate ----------------
    logic signed [WIDE_W-1:0]          wide;
    logic [WIDE_W-ODATA_WIDTH:0]       wide_upper;
    logic                              ovf;
    logic [ODATA_WIDTH-1:0]            odata_d, odata_q;

    assign wide       = WIDE_W'(s2_prod_q) <<< cfg_dequant_shift;
    // The value fits only if every bit above the output sign bit copies it.
    assign wide_upper = wide[WIDE_W-1:ODATA_WIDTH-1];
    assign ovf        = ~((&wide_upper) | ~(|wide_upper));
    assign odata_d    = ovf ? (wide[WIDE_W-1] ? SAT_MIN : SAT_MAX)
                            : wide[ODATA_WIDTH-1:0];
    assign odata      = odata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and stage order inside the block is irrelevant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s2_prod_q  <= '0;
            odata_q    <= '0;
        end else if (adv) begin
            s1_valid_q <= idata_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            if (idata_valid) s1_diff_q <= diff_d;
            if (s1_valid_q)  s2_prod_q <= prod_d;
            if (s2_valid_q)  odata_q   <= odata_d;
        end
    end

    // ---------------- vector boundary tagging ----------------
    logic                       out_hs;
    logic [CDATA_LEN_WIDTH-1:0] len_m1;
    logic [CDATA_LEN_WIDTH-1:0] cnt_d, cnt_q;

    assign out_hs     = s3_valid_q & odata_ready;
    assign len_m1     = (cfg_vec_len == '0) ? '0 : cfg_vec_len - 1'b1;
    // Derived from the counter, which moves only on a handshake, so the tag
    // stays attached to the held beat during a stall.
    assign odata_last = s3_valid_q & (cnt_q == len_m1);

    // NOTE: every variable in always_comb gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs) begin
            cnt_d = odata_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

`ifdef DEQUANT_SAT_CNT_EN
    // ---------------- saturation event counter ----------------
    logic        sat_q;
    logic [15:0] sat_cnt_d, sat_cnt_q;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (cfg_sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (out_hs && sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            // Clip flag travels with the S3 data it describes.
            if (adv && s2_valid_q) sat_q <= ovf;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_core_dequant.sv
// ---------------------------------------------------------------------------
// tb_core_dequant
//   Self-checking bench for core_dequant. Directed scenarios (latency,
//   saturation, stall, vector tagging, mid-stream reset, sign extension)
//   followed by randomized rounds. A negedge monitor scores every output
//   handshake against an arithmetic reference model and a vector-position
//   tracker.
// ---------------------------------------------------------------------------
module tb_core_dequant;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  cfg_dequant_zp = '0;
    logic [9:0]  cfg_dequant_scale = 10'd1;
    logic [4:0]  cfg_dequant_shift = '0;
    logic [15:0] cfg_vec_len = '0;
    logic [7:0]  idata = '0;
    logic        idata_valid = 1'b0;
    logic        idata_ready;
    logic [24:0] odata;
    logic        odata_valid;
    logic        odata_ready = 1'b1;
    logic        odata_last;
    logic        busy;
`ifdef DEQUANT_SAT_CNT_EN
    logic        cfg_sat_cnt_clr = 1'b0;
    logic [15:0] sat_cnt;
    logic [15:0] exp_sat = '0;
`endif

    core_dequant dut (
        .clk               (clk),
        .rstn              (rstn),
`ifdef DEQUANT_SAT_CNT_EN
        .cfg_sat_cnt_clr   (cfg_sat_cnt_clr),
        .sat_cnt           (sat_cnt),
`endif
        .cfg_dequant_zp    (cfg_dequant_zp),
        .cfg_dequant_scale (cfg_dequant_scale),
        .cfg_dequant_shift (cfg_dequant_shift),
        .cfg_vec_len       (cfg_vec_len),
        .idata             (idata),
        .idata_valid       (idata_valid),
        .idata_ready       (idata_ready),
        .odata             (odata),
        .odata_valid       (odata_valid),
        .odata_ready       (odata_ready),
        .odata_last        (odata_last),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [24:0] data;
        bit          sat;
    } exp_t;

    exp_t q[$];
    int   beat_in_vec = 0;
    int   out_beats = 0;
    int   out_lasts = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then clamp to the 25-bit range.
    function automatic exp_t model(input logic [7:0] d, input logic [7:0] zp,
                                   input logic [9:0] sc, input logic [4:0] sh);
        exp_t   r;
        longint v;
        v = longint'($signed(d)) - longint'($signed(zp));
        v = v * longint'(sc);
        v = v * (longint'(1) << sh);
        r.sat = 1'b0;
        if (v > 64'sd16777215) begin
            v = 64'sd16777215;
            r.sat = 1'b1;
        end else if (v < -64'sd16777216) begin
            v = -64'sd16777216;
            r.sat = 1'b1;
        end
        r.data = v[24:0];
        return r;
    endfunction

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        int   vlen;
        bit   exp_last;
        if (!rstn) begin
            q.delete();
            beat_in_vec = 0;
`ifdef DEQUANT_SAT_CNT_EN
            exp_sat = '0;
`endif
        end else begin
            check("ready_rule", {31'd0, idata_ready}, {31'd0, (!odata_valid || odata_ready)});
            check("busy_occupancy", {31'd0, busy}, {31'd0, (q.size() != 0)});
            if (odata_valid && odata_ready) begin
                out_beats++;
                if (odata_last) out_lasts++;
                if (q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("odata", {7'd0, odata}, {7'd0, e.data});
                    vlen = (cfg_vec_len == 0) ? 1 : int'(cfg_vec_len);
                    exp_last = (beat_in_vec == vlen - 1);
                    beat_in_vec = exp_last ? 0 : beat_in_vec + 1;
                    check("odata_last", {31'd0, odata_last}, {31'd0, exp_last});
`ifdef DEQUANT_SAT_CNT_EN
                    if (e.sat && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
`endif
                end
            end
`ifdef DEQUANT_SAT_CNT_EN
            if (cfg_sat_cnt_clr) exp_sat = '0;
`endif
            if (idata_valid && idata_ready)
                q.push_back(model(idata, cfg_dequant_zp, cfg_dequant_scale, cfg_dequant_shift));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push n elements; data is sequential from 'base' or random.
    task automatic send(input int n, input int base, input bit rnd_data, input bit rnd_hs);
        int  i;
        int  guard;
        bit  acc;
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            idata       = rnd_data ? 8'($urandom) : 8'(base + i);
            idata_valid = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            odata_ready = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            acc = idata_valid && idata_ready;
            step();
            if (acc) i++;
            guard++;
        end
        idata_valid = 1'b0;
        check("send_timeout", 32'(i), 32'(n));
    endtask

    task automatic drain();
        int n;
        idata_valid = 1'b0;
        odata_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        step();
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_queue", 32'(q.size()), 32'd0);
    endtask

    // One isolated element; reports edges from acceptance to output.
    task automatic single(input logic [7:0] v, output int lat, output logic [24:0] val);
        idata       = v;
        idata_valid = 1'b1;
        odata_ready = 1'b1;
        step();
        idata_valid = 1'b0;
        lat = 1;
        while (odata_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        val = odata;
        step();
    endtask

    task automatic set_cfg(input logic [7:0] zp, input logic [9:0] sc,
                           input logic [4:0] sh, input logic [15:0] len);
        cfg_dequant_zp    = zp;
        cfg_dequant_scale = sc;
        cfg_dequant_shift = sh;
        cfg_vec_len       = len;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        int          lat;
        logic [24:0] val;
        int          b0;
        int          l0;
        int          idx;
        bit          acc;

        // Reset state
        #1;
        check("rst_ready", {31'd0, idata_ready}, 32'd1);
        check("rst_valid", {31'd0, odata_valid}, 32'd0);
        check("rst_last",  {31'd0, odata_last},  32'd0);
        check("rst_busy",  {31'd0, busy},        32'd0);
        check("rst_odata", {7'd0, odata},        32'd0);
        step();
        step();
        rstn = 1'b1;
        step();

        // Sign extension without saturation
        set_cfg(8'd0, 10'd1, 5'd0, 16'd0);
        single(8'hFF, lat, val);
        check("neg_one", {7'd0, val}, {7'd0, 25'h1FFFFFF});

        // Basic value and latency
        set_cfg(8'd2, 10'd3, 5'd1, 16'd0);
        single(8'd5, lat, val);
        check("latency", 32'(lat), 32'd3);
        check("basic_18", {7'd0, val}, 32'd18);

        // Saturation at both rails
`ifdef DEQUANT_SAT_CNT_EN
        cfg_sat_cnt_clr = 1'b1;
        step();
        cfg_sat_cnt_clr = 1'b0;
`endif
        set_cfg(8'h80, 10'd1023, 5'd31, 16'd0);
        single(8'd127, lat, val);
        check("sat_pos", {7'd0, val}, {7'd0, 25'h0FFFFFF});
        set_cfg(8'd127, 10'd1023, 5'd20, 16'd0);
        single(8'h80, lat, val);
        check("sat_neg", {7'd0, val}, {7'd0, 25'h1000000});
`ifdef DEQUANT_SAT_CNT_EN
        check("sat_cnt_2", {16'd0, sat_cnt}, 32'd2);
        check("sat_cnt_model", {16'd0, sat_cnt}, {16'd0, exp_sat});
`endif

        // Stream 0..9 with a downstream stall in cycles 4..8
        set_cfg(8'd0, 10'd1, 5'd0, 16'd0);
        b0 = out_beats;
        idx = 0;
        for (int c = 0; c < 60 && (idx < 10 || busy); c++) begin
            idata_valid = (idx < 10);
            idata       = 8'(idx);
            odata_ready = !(c >= 4 && c <= 8);
            @(negedge clk);
            if (c >= 4 && c <= 8) check("stall_ready", {31'd0, idata_ready}, 32'd0);
            acc = idata_valid && idata_ready;
            step();
            if (acc) idx++;
        end
        drain();
        check("stream_accepted", 32'(idx), 32'd10);
        check("stream_beats", 32'(out_beats - b0), 32'd10);

        // Vector tagging
        set_cfg(8'd0, 10'd1, 5'd0, 16'd4);
        b0 = out_beats;
        l0 = out_lasts;
        send(8, 20, 1'b0, 1'b0);
        drain();
        check("len4_beats", 32'(out_beats - b0), 32'd8);
        check("len4_lasts", 32'(out_lasts - l0), 32'd2);
        set_cfg(8'd0, 10'd1, 5'd0, 16'd0);
        l0 = out_lasts;
        send(3, 40, 1'b0, 1'b0);
        drain();
        check("len0_lasts", 32'(out_lasts - l0), 32'd3);

        // Reset with three beats in flight
        set_cfg(8'd0, 10'd1, 5'd0, 16'd3);
        odata_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idata       = 8'(60 + i);
            idata_valid = 1'b1;
            step();
        end
        idata_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, odata_valid}, 32'd0);
        check("midrst_busy",  {31'd0, busy},        32'd0);
        check("midrst_last",  {31'd0, odata_last},  32'd0);
        check("midrst_odata", {7'd0, odata},        32'd0);
        step();
        step();
        rstn = 1'b1;
        step();
        l0 = out_lasts;
        send(3, 70, 1'b0, 1'b0);
        drain();
        check("postrst_lasts", 32'(out_lasts - l0), 32'd1);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            pulse_reset();
            set_cfg(8'($urandom), 10'($urandom),
                    ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 8)) : 5'($urandom),
                    16'($urandom_range(0, 5)));
            send($urandom_range(10, 40), 0, 1'b1, 1'b1);
            drain();
`ifdef DEQUANT_SAT_CNT_EN
            check("rand_sat_cnt", {16'd0, sat_cnt}, {16'd0, exp_sat});
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
